// File: rtl/pc_sequencer.sv
// Program-counter sequencer: owns the PC and picks the next fetch address from
// sequential, branch, JAL, JALR and trap-vector sources, with a post-reset hold.
module pc_sequencer #(
  parameter int              XLEN         = 32,
  parameter int              IMM_W        = 64,
  parameter logic [XLEN-1:0] RESET_VECTOR = '0,
  parameter logic [XLEN-1:0] TRAP_VECTOR  = 'h100,
  parameter int              IMM_SHIFT    = 1,
  parameter int              HOLD_CYCLES  = 2,
  parameter int              CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [1:0]       pc_sel,
  input  logic [2:0]       br_type,
  input  logic             alu_zero,
  input  logic             alu_lt,
  input  logic             alu_ltu,
  input  logic [IMM_W-1:0] imm,
  input  logic [XLEN-1:0]  rs1_val,
  input  logic             trap_ack,
  output logic [XLEN-1:0]  pc_out,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             fetch_valid,
  output logic             taken,
  output logic             misalign,
  output logic [XLEN-1:0]  epc_out,
  output logic [CNT_W-1:0] taken_cnt
);

  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    TRAP = 2'd2
  } state_t;

  localparam logic [1:0] SEL_SEQ    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JAL    = 2'b10;

  state_t            state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic [XLEN-1:0]   pc_d, epc_d;
  logic [CNT_W-1:0]  cnt_d;
  logic              taken_d, misalign_d;

  logic [XLEN-1:0]   imm_lo;
  logic [XLEN-1:0]   rel_target;
  logic [XLEN-1:0]   jalr_target;
  logic [XLEN-1:0]   target;
  logic              branch_cond;
  logic              redirect;

  assign imm_lo = imm[XLEN-1:0];

  generate
    if (IMM_W > XLEN) begin : g_imm_hi
      logic unused_imm_hi;
      assign unused_imm_hi = ^imm[IMM_W-1:XLEN];
    end
  endgenerate

  assign rel_target  = pc_out + (imm_lo << IMM_SHIFT);
  assign jalr_target = (rs1_val + imm_lo) & ~XLEN'(1);
  assign pc_plus4    = pc_out + XLEN'(4);
  assign fetch_valid = (state_q == RUN);

  // Encodings 010/011 are not branch compares and must never redirect.
  always_comb begin
    branch_cond = 1'b0;
    unique case (br_type)
      3'b000:  branch_cond = alu_zero;
      3'b001:  branch_cond = ~alu_zero;
      3'b100:  branch_cond = alu_lt;
      3'b101:  branch_cond = ~alu_lt;
      3'b110:  branch_cond = alu_ltu;
      3'b111:  branch_cond = ~alu_ltu;
      default: branch_cond = 1'b0;
    endcase
  end

  always_comb begin
    target   = rel_target;
    redirect = 1'b0;
    unique case (pc_sel)
      SEL_SEQ:    redirect = 1'b0;
      SEL_BRANCH: redirect = branch_cond;
      SEL_JAL:    redirect = 1'b1;
      default: begin
        target   = jalr_target;
        redirect = 1'b1;
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    pc_d       = pc_out;
    epc_d      = epc_out;
    cnt_d      = taken_cnt;
    taken_d    = 1'b0;
    misalign_d = 1'b0;
    unique case (state_q)
      HOLD: begin
        if (hold_q == HOLD_W'(HOLD_CYCLES - 1)) begin
          state_d = RUN;
          hold_d  = '0;
        end else begin
          hold_d = hold_q + HOLD_W'(1);
        end
      end
      RUN: begin
        if (!stall) begin
          if (redirect && (target[1:0] != 2'b00)) begin
            // Faulting redirect: record the offending PC and divert to the trap vector.
            pc_d       = TRAP_VECTOR;
            epc_d      = pc_out;
            misalign_d = 1'b1;
            state_d    = TRAP;
          end else if (redirect) begin
            pc_d    = target;
            taken_d = 1'b1;
            if (taken_cnt != '1) begin
              cnt_d = taken_cnt + CNT_W'(1);
            end
          end else begin
            pc_d = pc_plus4;
          end
        end
      end
      TRAP: begin
        if (trap_ack) begin
          state_d = RUN;
        end
      end
      default: state_d = HOLD;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= HOLD;
      hold_q    <= '0;
      pc_out    <= RESET_VECTOR;
      epc_out   <= '0;
      taken_cnt <= '0;
      taken     <= 1'b0;
      misalign  <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      pc_out    <= pc_d;
      epc_out   <= epc_d;
      taken_cnt <= cnt_d;
      taken     <= taken_d;
      misalign  <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural model pushes expected outputs to a
// scoreboard queue as each step is driven; they are popped and checked after the edge.
module tb_pc_sequencer;

  localparam int CNT_W       = 2;
  localparam int HOLD_CYCLES = 2;

  logic        clk;
  logic        reset;
  logic        stall;
  logic [1:0]  pc_sel;
  logic [2:0]  br_type;
  logic        alu_zero;
  logic        alu_lt;
  logic        alu_ltu;
  logic [63:0] imm;
  logic [31:0] rs1_val;
  logic        trap_ack;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        fetch_valid;
  logic        taken;
  logic        misalign;
  logic [31:0] epc_out;
  logic [CNT_W-1:0] taken_cnt;

  pc_sequencer #(.CNT_W(CNT_W), .HOLD_CYCLES(HOLD_CYCLES)) dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_sel(pc_sel), .br_type(br_type),
    .alu_zero(alu_zero), .alu_lt(alu_lt), .alu_ltu(alu_ltu), .imm(imm),
    .rs1_val(rs1_val), .trap_ack(trap_ack), .pc_out(pc_out), .pc_plus4(pc_plus4),
    .fetch_valid(fetch_valid), .taken(taken), .misalign(misalign),
    .epc_out(epc_out), .taken_cnt(taken_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] epc;
    logic [31:0] cnt;
    logic        tk;
    logic        mis;
    logic        fv;
  } exp_t;

  exp_t scoreboard[$];

  int checks = 0;
  int errors = 0;

  // Reference model: 0=hold, 1=run, 2=trap
  int          m_mode;
  int          m_hold_left;
  logic [31:0] m_pc, m_epc, m_cnt;
  logic        m_tk, m_mis;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_hold_left = HOLD_CYCLES;
    m_pc = 32'h0; m_epc = 32'h0; m_cnt = 32'h0; m_tk = 1'b0; m_mis = 1'b0;
  endtask

  task automatic check_outputs(input string tag, input exp_t e);
    check({tag, ".pc"},       pc_out,            e.pc);
    check({tag, ".pc4"},      pc_plus4,          e.pc + 32'd4);
    check({tag, ".fv"},       {31'd0, fetch_valid}, {31'd0, e.fv});
    check({tag, ".taken"},    {31'd0, taken},    {31'd0, e.tk});
    check({tag, ".misalign"}, {31'd0, misalign}, {31'd0, e.mis});
    check({tag, ".epc"},      epc_out,           e.epc);
    check({tag, ".cnt"},      {30'd0, taken_cnt}, e.cnt);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, ".pc"},  pc_out, 32'h0);
    check({tag, ".fv"},  {31'd0, fetch_valid}, 32'd0);
    check({tag, ".tk"},  {31'd0, taken}, 32'd0);
    check({tag, ".mis"}, {31'd0, misalign}, 32'd0);
    check({tag, ".epc"}, epc_out, 32'h0);
    check({tag, ".cnt"}, {30'd0, taken_cnt}, 32'd0);
  endtask

  task automatic applyStimulus(input string tag, input logic [1:0] sel, input logic [2:0] bt,
                               input logic z, input logic lt, input logic ltu,
                               input logic [63:0] im, input logic [31:0] rs1,
                               input logic st, input logic ack);
    exp_t        e;
    logic        cond, tk;
    logic [31:0] tgt;
    stall = st; pc_sel = sel; br_type = bt; alu_zero = z; alu_lt = lt; alu_ltu = ltu;
    imm = im; rs1_val = rs1; trap_ack = ack;
    m_tk = 1'b0; m_mis = 1'b0;
    if (m_mode == 0) begin
      m_hold_left--;
      if (m_hold_left == 0) m_mode = 1;
    end else if (m_mode == 2) begin
      if (ack) m_mode = 1;
    end else if (!st) begin
      case (bt)
        3'b000: cond = z;
        3'b001: cond = !z;
        3'b100: cond = lt;
        3'b101: cond = !lt;
        3'b110: cond = ltu;
        3'b111: cond = !ltu;
        default: cond = 1'b0;
      endcase
      tk  = (sel == 2'b01) ? cond : (sel[1] == 1'b1);
      tgt = (sel == 2'b11) ? ((rs1 + im[31:0]) & 32'hFFFF_FFFE) : (m_pc + (im[31:0] << 1));
      if (tk && tgt[1:0] != 2'b00) begin
        m_epc = m_pc; m_pc = 32'h100; m_mis = 1'b1; m_mode = 2;
      end else if (tk) begin
        m_pc = tgt; m_tk = 1'b1;
        if (m_cnt < 32'd3) m_cnt = m_cnt + 32'd1;
      end else begin
        m_pc = m_pc + 32'd4;
      end
    end
    e.pc = m_pc; e.epc = m_epc; e.cnt = m_cnt; e.tk = m_tk; e.mis = m_mis; e.fv = (m_mode == 1);
    scoreboard.push_back(e);
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  task automatic checkOutput(input string tag);
    exp_t e;
    if (scoreboard.size() == 0) begin
      checks++; errors++;
      $error("[TB] FAIL %s: observed=empty-scoreboard expected=entry", tag);
    end else begin
      e = scoreboard.pop_front();
      check_outputs(tag, e);
    end
  endtask

  task automatic seq(input string tag, input logic ack);
    applyStimulus(tag, 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'd0, 32'd0, 1'b0, ack);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; pc_sel = 2'b00; br_type = 3'b000; alu_zero = 1'b0;
    alu_lt = 1'b0; alu_ltu = 1'b0; imm = 64'd0; rs1_val = 32'd0; trap_ack = 1'b0;
    model_reset();
    #1;
    check_reset_values("por");
    check("por.pc4", pc_plus4, 32'h4);
    release_reset();

    seq("hold1", 1'b0);
    seq("hold2", 1'b0);
    check("run_fv", {31'd0, fetch_valid}, 32'd1);
    seq("seq4", 1'b0);
    seq("seq8", 1'b0);
    check("seq8_pc", pc_out, 32'h8);
    for (int i = 0; i < 14; i++) seq("seq_walk", 1'b0);
    check("at40", pc_out, 32'h40);

    applyStimulus("bne_tk", 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 64'h10, 32'd0, 1'b0, 1'b0);
    check("bne_tk_pc", pc_out, 32'h60);
    check("bne_tk_cnt", {30'd0, taken_cnt}, 32'd1);
    applyStimulus("bne_nt", 2'b01, 3'b001, 1'b1, 1'b0, 1'b0, 64'h10, 32'd0, 1'b0, 1'b0);
    check("bne_nt_pc", pc_out, 32'h64);
    seq("ack_ignored", 1'b1);
    applyStimulus("beq_odd_nt", 2'b01, 3'b000, 1'b0, 1'b0, 1'b0, 64'h1, 32'd0, 1'b0, 1'b0);

    applyStimulus("jalr_mis", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 32'h1003, 1'b0, 1'b0);
    check("jalr_mis_epc", epc_out, 32'h6C);
    check("jalr_mis_pc", pc_out, 32'h100);
    seq("trap_wait", 1'b0);
    applyStimulus("trap_ack_stall", 2'b00, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 32'd0, 1'b1, 1'b1);
    check("trap_ack_cnt", {30'd0, taken_cnt}, 32'd1);

    applyStimulus("jal_back", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFC0, 32'd0, 1'b0, 1'b0);
    applyStimulus("bltu_neg", 2'b01, 3'b110, 1'b0, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFF8, 32'd0, 1'b0, 1'b0);
    check("bltu_neg_pc", pc_out, 32'h70);
    applyStimulus("blt_tk",  2'b01, 3'b100, 1'b0, 1'b1, 1'b0, 64'h4, 32'd0, 1'b0, 1'b0);
    applyStimulus("bge_nt",  2'b01, 3'b101, 1'b0, 1'b1, 1'b0, 64'h4, 32'd0, 1'b0, 1'b0);
    applyStimulus("bgeu_tk", 2'b01, 3'b111, 1'b0, 1'b0, 1'b0, 64'h2, 32'd0, 1'b0, 1'b0);
    applyStimulus("bt010",   2'b01, 3'b010, 1'b1, 1'b1, 1'b1, 64'h4, 32'd0, 1'b0, 1'b0);
    applyStimulus("bt011",   2'b01, 3'b011, 1'b1, 1'b1, 1'b1, 64'h4, 32'd0, 1'b0, 1'b0);
    applyStimulus("beq_tk",  2'b01, 3'b000, 1'b1, 1'b0, 1'b0, 64'h2, 32'd0, 1'b0, 1'b0);
    check("cnt_sat", {30'd0, taken_cnt}, 32'd3);

    applyStimulus("bne_odd_tk", 2'b01, 3'b001, 1'b0, 1'b0, 1'b0, 64'h1, 32'd0, 1'b0, 1'b0);
    seq("trap_ack2", 1'b1);

    for (int i = 0; i < 3; i++)
      applyStimulus("jal_stall", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 64'h20, 32'd0, 1'b1, 1'b0);
    applyStimulus("jal_go", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 64'h20, 32'd0, 1'b0, 1'b0);
    check("jal_go_pc", pc_out, 32'h140);

    applyStimulus("jalr_top", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 32'hFFFF_FFFD, 1'b0, 1'b0);
    check("wrap_pc4", pc_plus4, 32'h0);
    seq("wrap_seq", 1'b0);
    check("wrap_pc", pc_out, 32'h0);

    applyStimulus("pre_rst_stall", 2'b10, 3'b000, 1'b0, 1'b0, 1'b0, 64'h20, 32'd0, 1'b1, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_stall");
    release_reset();
    seq("rehold1", 1'b0);
    seq("rehold2", 1'b0);

    applyStimulus("jalr_mis2", 2'b11, 3'b000, 1'b0, 1'b0, 1'b0, 64'h0, 32'h2, 1'b0, 1'b0);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_trap");
    release_reset();
    seq("rehold3", 1'b0);
    seq("rehold4", 1'b0);
    seq("rerun", 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer, the next generation of the single-cycle PC update block. It owns the PC register internally and selects the next PC from five sources: sequential, conditional branch (six RISC-V compare types), JAL, JALR and trap vector. It adds a stall input, a post-reset hold, misaligned-target trapping with an exception PC, and a saturating taken-redirect counter. It sits between decode/execute and instruction fetch.

Parameters:
XLEN, 32, PC and operand width
IMM_W, 64, immediate input width; low XLEN bits used
RESET_VECTOR, 0, PC value loaded by reset
TRAP_VECTOR, 32'h100, PC loaded on misaligned-target trap
IMM_SHIFT, 1, left shift applied to immediate for branch/JAL targets
HOLD_CYCLES, 2, cycles fetch_valid stays low after reset deasserts (>=1)
CNT_W, 16, taken-redirect counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high
stall  in  1  hold PC, counter and state
pc_sel  in  2  00 seq, 01 branch, 10 JAL, 11 JALR
br_type  in  3  000 BEQ, 001 BNE, 100 BLT, 101 BGE, 110 BLTU, 111 BGEU; 010/011 never taken
alu_zero  in  1  rs1==rs2
alu_lt  in  1  signed rs1<rs2
alu_ltu  in  1  unsigned rs1<rs2
imm  in  IMM_W  sign-extended immediate
rs1_val  in  XLEN  JALR base
trap_ack  in  1  one-cycle pulse releasing TRAP state
pc_out  out  XLEN  current PC (registered)
pc_plus4  out  XLEN  pc_out+4, combinational link value
fetch_valid  out  1  pc_out is a valid fetch address
taken  out  1  registered: last PC update was a non-sequential redirect
misalign  out  1  registered one-cycle pulse on trap entry
epc_out  out  XLEN  PC of instruction whose target faulted
taken_cnt  out  CNT_W  count of taken redirects

Behaviour:
- Reset (async, any state): pc_out=RESET_VECTOR, epc_out=0, taken=0, misalign=0, taken_cnt=0, fetch_valid=0, state=HOLD, hold counter=0.
- States: HOLD, RUN, TRAP.
- HOLD: fetch_valid=0, PC frozen; counter increments each cycle; after HOLD_CYCLES cycles -> RUN. stall ignored in HOLD.
- RUN: fetch_valid=1. If stall=1: all registers hold, taken/misalign drop to 0. Else compute next PC:
  - seq: pc+4.
  - branch: condition per br_type from flags; taken -> pc + (imm[XLEN-1:0] << IMM_SHIFT), else pc+4.
  - JAL: pc + (imm[XLEN-1:0] << IMM_SHIFT), always taken.
  - JALR: (rs1_val + imm[XLEN-1:0]) with bit0 cleared, always taken.
  - All adds modulo 2^XLEN; wrap-around silent.
- Misalignment: taken target with bits[1:0]!=00 -> pc_out=TRAP_VECTOR, epc_out=current pc_out, misalign=1 for one cycle, taken=0, counter unchanged, state=TRAP. Not-taken branches never trap.
- TRAP: fetch_valid=0, PC frozen at TRAP_VECTOR; trap_ack=1 -> RUN next cycle (fetch_valid=1 at TRAP_VECTOR). trap_ack outside TRAP ignored; stall does not block trap_ack.
- taken=1 for exactly the cycle after a non-faulting taken redirect; taken_cnt increments on the same edge, saturates at all-ones.
- Latency: one cycle from control inputs to pc_out.
- pc_plus4 always pc_out+4 mod 2^XLEN, irrespective of state.
- Reset asserted mid-HOLD/TRAP/stall: immediate return to reset values.

Test Plan:
- Reset then release: pc_out=0, fetch_valid=0 for 2 cycles, then 1; seq -> pc_out 0,4,8 on successive edges.
- At pc=0x40, pc_sel=01, br_type=BNE, alu_zero=0, imm=0x10 -> pc_out=0x60, taken=1, taken_cnt=1; same with alu_zero=1 -> pc_out=0x44, taken=0.
- At pc=0x80, BLTU with alu_ltu=1, imm=-8 (all ones..F8) -> pc_out=0x70; at pc=0xFFFFFFFC seq -> pc_out=0 (wrap).
- JALR with rs1_val=0x1003, imm=0 -> target 0x1002 misaligned -> pc_out=0x100, epc_out=old pc, misalign pulse, fetch_valid=0 until trap_ack, then RUN at 0x100, taken_cnt unchanged.
- stall=1 during JAL imm=0x20 for 3 cycles -> pc_out frozen; stall drop -> pc_out=pc+0x40; CNT_W=2 bench: 4 taken redirects -> taken_cnt stays 3.
- Assert reset mid-TRAP and mid-stall -> outputs return to reset values within the same cycle, HOLD restarts.
